// File: rtl/gemm_tile_scheduler_if.sv
// Control and SRAM/MAC interface of the GeMM tile scheduler.
// master = scheduler side, slave = surrounding datapath / controller.
interface gemm_tile_scheduler_if #(
  parameter int SizeAddrWidth = 8,
  parameter int AddrWidth     = 16
);
  logic                     start_i;
  logic                     stall_i;
  logic [SizeAddrWidth-1:0] M_size_i;
  logic [SizeAddrWidth-1:0] K_size_i;
  logic [SizeAddrWidth-1:0] N_size_i;
  logic [AddrWidth-1:0]     sram_a_addr_o;
  logic [AddrWidth-1:0]     sram_b_addr_o;
  logic                     operand_valid_o;
  logic                     acc_init_o;
  logic                     sram_c_we_o;
  logic [AddrWidth-1:0]     sram_c_addr_o;
  logic                     busy_o;
  logic                     done_o;
  logic [31:0]              perf_cycles_o;
  logic [31:0]              perf_stalls_o;

  modport master (
    input  start_i, stall_i, M_size_i, K_size_i, N_size_i,
    output sram_a_addr_o, sram_b_addr_o, operand_valid_o, acc_init_o,
           sram_c_we_o, sram_c_addr_o, busy_o, done_o,
           perf_cycles_o, perf_stalls_o
  );

  modport slave (
    output start_i, stall_i, M_size_i, K_size_i, N_size_i,
    input  sram_a_addr_o, sram_b_addr_o, operand_valid_o, acc_init_o,
           sram_c_we_o, sram_c_addr_o, busy_o, done_o,
           perf_cycles_o, perf_stalls_o
  );
endinterface

// File: rtl/gemm_tile_scheduler.sv
// Block-level GeMM loop sequencer (M outer, N middle, K inner) with latency-matched writeback.
// Optional performance counters are enabled by defining GEMM_SCHED_PERF_CNT_EN.
module gemm_tile_scheduler #(
  parameter int SizeAddrWidth = 8,
  parameter int AddrWidth     = 16,
  parameter int ReadLatency   = 1,
  parameter int MacLatency    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  gemm_tile_scheduler_if.master sched
);
  localparam int ProdWidth  = 2 * SizeAddrWidth;
  localparam int WbLatency  = ReadLatency + MacLatency;
  localparam int DrainWidth = $clog2(WbLatency + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                   r_state, w_next_state;
  logic [SizeAddrWidth-1:0] r_m_size, r_k_size, r_n_size;
  logic [SizeAddrWidth-1:0] r_m, r_n, r_k;
  logic [DrainWidth-1:0]    r_drain_cnt;
  logic                     w_issue, w_busy, w_done, w_start_ok, w_any_zero;
  logic                     w_k_last, w_n_last, w_m_last, w_wb_issue;
  logic [ProdWidth-1:0]     w_a_full, w_b_full, w_c_full;
  logic [AddrWidth-1:0]     w_a_addr, w_b_addr, w_c_addr;
  logic [AddrWidth-1:0]     r_a_hold, r_b_hold;
  logic [ReadLatency-1:0]   r_ov_pipe, r_init_pipe;
  logic [WbLatency-1:0]     r_we_pipe;
  logic [AddrWidth-1:0]     r_c_pipe [WbLatency];

  assign w_start_ok = (r_state == S_IDLE) && sched.start_i;
  assign w_any_zero = (sched.M_size_i == '0) || (sched.K_size_i == '0) ||
                      (sched.N_size_i == '0);
  assign w_k_last   = (r_k == r_k_size - SizeAddrWidth'(1));
  assign w_n_last   = (r_n == r_n_size - SizeAddrWidth'(1));
  assign w_m_last   = (r_m == r_m_size - SizeAddrWidth'(1));
  assign w_wb_issue = w_issue && w_k_last;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (sched.start_i) w_next_state = w_any_zero ? S_DONE : S_RUN;
      S_RUN:   if (w_issue && w_k_last && w_n_last && w_m_last) w_next_state = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == DrainWidth'(WbLatency - 1)) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_issue = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE:  w_busy  = 1'b0;
      S_RUN:   w_issue = !sched.stall_i;
      S_DONE:  w_done  = 1'b1;
      default: ;
    endcase
  end

  // Loop counters: k fastest, then n, then m.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_m_size <= '0;
      r_k_size <= '0;
      r_n_size <= '0;
      r_m      <= '0;
      r_n      <= '0;
      r_k      <= '0;
    end else if (w_start_ok) begin
      r_m_size <= sched.M_size_i;
      r_k_size <= sched.K_size_i;
      r_n_size <= sched.N_size_i;
      r_m      <= '0;
      r_n      <= '0;
      r_k      <= '0;
    end else if (w_issue) begin
      if (w_k_last) begin
        r_k <= '0;
        if (w_n_last) begin
          r_n <= '0;
          r_m <= r_m + SizeAddrWidth'(1);
        end else begin
          r_n <= r_n + SizeAddrWidth'(1);
        end
      end else begin
        r_k <= r_k + SizeAddrWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  r_drain_cnt <= '0;
    else if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + DrainWidth'(1);
    else                        r_drain_cnt <= '0;
  end

  assign w_a_full = ProdWidth'(r_m) * ProdWidth'(r_k_size) + ProdWidth'(r_k);
  assign w_b_full = ProdWidth'(r_n) * ProdWidth'(r_k_size) + ProdWidth'(r_k);
  assign w_c_full = ProdWidth'(r_m) * ProdWidth'(r_n_size) + ProdWidth'(r_n);
  assign w_a_addr = AddrWidth'(w_a_full);
  assign w_b_addr = AddrWidth'(w_b_full);
  assign w_c_addr = AddrWidth'(w_c_full);

  // Addresses follow the counters while issuing and hold the last issued value otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a_hold <= '0;
      r_b_hold <= '0;
    end else if (w_issue) begin
      r_a_hold <= w_a_addr;
      r_b_hold <= w_b_addr;
    end
  end

  // NOTE: the C-address delay line is reset too, so an aborted job can never emit a stale write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ov_pipe   <= '0;
      r_init_pipe <= '0;
      r_we_pipe   <= '0;
      for (int i = 0; i < WbLatency; i++) r_c_pipe[i] <= '0;
    end else begin
      r_ov_pipe[0]   <= w_issue;
      r_init_pipe[0] <= w_issue && (r_k == '0);
      r_we_pipe[0]   <= w_wb_issue;
      r_c_pipe[0]    <= w_wb_issue ? w_c_addr : '0;
      for (int i = 1; i < ReadLatency; i++) begin
        r_ov_pipe[i]   <= r_ov_pipe[i-1];
        r_init_pipe[i] <= r_init_pipe[i-1];
      end
      for (int i = 1; i < WbLatency; i++) begin
        r_we_pipe[i] <= r_we_pipe[i-1];
        r_c_pipe[i]  <= r_c_pipe[i-1];
      end
    end
  end

  assign sched.sram_a_addr_o   = w_issue ? w_a_addr : r_a_hold;
  assign sched.sram_b_addr_o   = w_issue ? w_b_addr : r_b_hold;
  assign sched.operand_valid_o = r_ov_pipe[ReadLatency-1];
  assign sched.acc_init_o      = r_init_pipe[ReadLatency-1];
  assign sched.sram_c_we_o     = r_we_pipe[WbLatency-1];
  assign sched.sram_c_addr_o   = r_c_pipe[WbLatency-1];
  assign sched.busy_o          = w_busy;
  assign sched.done_o          = w_done;

`ifdef GEMM_SCHED_PERF_CNT_EN
  logic [31:0] r_perf_cycles, r_perf_stalls;

  // Saturating counters, cleared by an accepted start and frozen while idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else if (w_start_ok) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_busy && (r_perf_cycles != '1))
        r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_state == S_RUN) && sched.stall_i && (r_perf_stalls != '1))
        r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign sched.perf_cycles_o = r_perf_cycles;
  assign sched.perf_stalls_o = r_perf_stalls;
`else
  assign sched.perf_cycles_o = '0;
  assign sched.perf_stalls_o = '0;
`endif
endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Scoreboard bench for gemm_tile_scheduler at default latencies (ReadLatency = MacLatency = 1).
// Cycle numbers are relative to the cycle in which start_i is driven high (cycle 0).
module tb_gemm_tile_scheduler;
  typedef struct {
    int cyc;
    int a;
    int b;
    int acc;
  } op_t;

  typedef struct {
    int cyc;
    int c;
  } we_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   t0  = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_total = 0;
  int   done_total = 0;
  int   busy_base  = 0;
  int   done_base  = 0;
  logic [15:0] prev_a = '0;
  logic [15:0] prev_b = '0;

  op_t exp_op[$];
  we_t exp_we[$];
  int  exp_done[$];

  int a_tab[12]   = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
  int b_tab[12]   = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
  int acc_tab[12] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};

  gemm_tile_scheduler_if #(.SizeAddrWidth(8), .AddrWidth(16)) u_if ();

  gemm_tile_scheduler #(
    .SizeAddrWidth(8),
    .AddrWidth(16),
    .ReadLatency(1),
    .MacLatency(1)
  ) u_dut (
    .clk_i(clk),
    .rst_i(rst),
    .sched(u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_op(input int c, input int a, input int b, input int acc);
    op_t e;
    e.cyc = c; e.a = a; e.b = b; e.acc = acc;
    exp_op.push_back(e);
  endtask

  task automatic push_we(input int c, input int addr);
    we_t e;
    e.cyc = c; e.c = addr;
    exp_we.push_back(e);
  endtask

  // Unstalled job: issue i (1-based) at cycle i, operands at i+1, write at i+2, done at last+3.
  task automatic push_model(input int m, input int k, input int n);
    int idx = 0;
    for (int mi = 0; mi < m; mi++)
      for (int ni = 0; ni < n; ni++)
        for (int ki = 0; ki < k; ki++) begin
          idx++;
          push_op(idx + 1, mi * k + ki, ni * k + ki, (ki == 0) ? 1 : 0);
          if (ki == k - 1) push_we(idx + 2, mi * n + ni);
        end
    exp_done.push_back(idx + 3);
  endtask

  // Returns 1 ns into cycle 1; sizes are scrambled after the latch edge.
  task automatic start_job(input int m, input int k, input int n);
    @(posedge clk); #1;
    u_if.M_size_i = 8'(m);
    u_if.K_size_i = 8'(k);
    u_if.N_size_i = 8'(n);
    u_if.start_i  = 1'b1;
    t0        = cyc;
    busy_base = busy_total;
    done_base = done_total;
    @(posedge clk); #1;
    u_if.start_i  = 1'b0;
    u_if.M_size_i = 8'd7;
    u_if.K_size_i = 8'd7;
    u_if.N_size_i = 8'd7;
  endtask

  task automatic wait_done(input int exp_busy);
    for (int i = 0; i < 200 && done_total == done_base; i++) @(posedge clk);
    if (done_total == done_base) check("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("busy_cycles", busy_total - busy_base, exp_busy);
    check("op_left", exp_op.size(), 0);
    check("we_left", exp_we.size(), 0);
    check("done_left", exp_done.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_addr"}, u_if.sram_a_addr_o, 0);
    check({tag, "_b_addr"}, u_if.sram_b_addr_o, 0);
    check({tag, "_op_valid"}, u_if.operand_valid_o, 0);
    check({tag, "_acc_init"}, u_if.acc_init_o, 0);
    check({tag, "_c_we"}, u_if.sram_c_we_o, 0);
    check({tag, "_c_addr"}, u_if.sram_c_addr_o, 0);
    check({tag, "_busy"}, u_if.busy_o, 0);
    check({tag, "_done"}, u_if.done_o, 0);
    check({tag, "_perf_cycles"}, u_if.perf_cycles_o, 0);
    check({tag, "_perf_stalls"}, u_if.perf_stalls_o, 0);
  endtask

  task automatic check_perf(input int exp_cycles, input int exp_stalls);
`ifdef GEMM_SCHED_PERF_CNT_EN
    check("perf_cycles", u_if.perf_cycles_o, exp_cycles);
    check("perf_stalls", u_if.perf_stalls_o, exp_stalls);
`else
    check("perf_cycles_off", u_if.perf_cycles_o, exp_cycles * 0);
    check("perf_stalls_off", u_if.perf_stalls_o, exp_stalls * 0);
`endif
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    op_t eo;
    we_t ew;
    int  ed;
    int  rel;
    forever begin
      @(negedge clk);
      rel = cyc - t0;
      if (u_if.operand_valid_o) begin
        if (exp_op.size() == 0) check("op_unexpected", 1, 0);
        else begin
          eo = exp_op.pop_front();
          check("op_cycle", rel, eo.cyc);
          check("a_addr", prev_a, eo.a);
          check("b_addr", prev_b, eo.b);
          check("acc_init", u_if.acc_init_o, eo.acc);
        end
      end else if (u_if.acc_init_o) begin
        check("acc_init_stray", 1, 0);
      end
      if (u_if.sram_c_we_o) begin
        if (exp_we.size() == 0) check("we_unexpected", 1, 0);
        else begin
          ew = exp_we.pop_front();
          check("we_cycle", rel, ew.cyc);
          check("c_addr", u_if.sram_c_addr_o, ew.c);
        end
      end else if (u_if.sram_c_addr_o != '0) begin
        check("c_addr_idle", u_if.sram_c_addr_o, 0);
      end
      if (u_if.done_o) begin
        done_total++;
        if (exp_done.size() == 0) check("done_unexpected", 1, 0);
        else begin
          ed = exp_done.pop_front();
          check("done_cycle", rel, ed);
        end
      end
      if (u_if.busy_o) busy_total++;
      prev_a = u_if.sram_a_addr_o;
      prev_b = u_if.sram_b_addr_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_if.start_i  = 1'b0;
    u_if.stall_i  = 1'b0;
    u_if.M_size_i = '0;
    u_if.K_size_i = '0;
    u_if.N_size_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1x1x1 job
    push_op(2, 0, 0, 1);
    push_we(3, 0);
    exp_done.push_back(4);
    start_job(1, 1, 1);
    wait_done(4);
    check_perf(4, 0);

    // M=2, K=3, N=2 from hand-written tables
    for (int i = 0; i < 12; i++) push_op(i + 2, a_tab[i], b_tab[i], acc_tab[i]);
    push_we(5, 0);
    push_we(8, 1);
    push_we(11, 2);
    push_we(14, 3);
    exp_done.push_back(15);
    start_job(2, 3, 2);
    wait_done(15);
    check_perf(15, 0);

    // K=0: straight to DONE, no operands or writes
    exp_done.push_back(1);
    start_job(2, 0, 2);
    wait_done(1);

    // 1x2x1 with stall_i high in cycles 2-3
    push_op(2, 0, 0, 1);
    push_op(5, 1, 1, 0);
    push_we(6, 0);
    exp_done.push_back(7);
    start_job(1, 2, 1);
    @(posedge clk); #1;
    u_if.stall_i = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    u_if.stall_i = 1'b0;
    wait_done(7);
    check_perf(7, 2);

    // 2x2x2 with a second start pulse in cycle 3 that must be ignored
    push_model(2, 2, 2);
    start_job(2, 2, 2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    u_if.M_size_i = 8'd1;
    u_if.K_size_i = 8'd1;
    u_if.N_size_i = 8'd1;
    u_if.start_i  = 1'b1;
    @(posedge clk); #1;
    u_if.start_i  = 1'b0;
    wait_done(11);
    check_perf(11, 0);

    // 2x2x2 aborted by reset in cycle 4
    push_model(2, 2, 2);
    start_job(2, 2, 2);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    exp_op.delete();
    exp_we.delete();
    exp_done.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", done_total - done_base, 0);
    check("abort_idle", u_if.busy_o, 0);

    // Clean job after the abort
    push_op(2, 0, 0, 1);
    push_we(3, 0);
    exp_done.push_back(4);
    start_job(1, 1, 1);
    wait_done(4);
    check_perf(4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
